// File: rtl/seq_serial_comparator_pkg.sv
// Shared encodings and helpers for the bit-serial magnitude comparator.
package seq_serial_comparator_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        REL_EQ = 2'b00,
        REL_LT = 2'b01,
        REL_GT = 2'b10
    } rel_t;

    // Map a relation onto the {L,E,G} output triple; illegal codes give all-zero.
    function automatic logic [2:0] rel_to_lge(input rel_t rel);
        logic [2:0] lge;
        case (rel)
            REL_LT:  lge = 3'b100;
            REL_EQ:  lge = 3'b010;
            REL_GT:  lge = 3'b001;
            default: lge = 3'b000;
        endcase
        return lge;
    endfunction

endpackage

// File: rtl/seq_cmp_step.sv
// One step of the serial compare: folds a single bit pair into the running relation.
module seq_cmp_step
    import seq_serial_comparator_pkg::*;
(
    input  rel_t rel,
    input  logic a,
    input  logic b,
    input  logic sign_bit,
    input  logic is_signed,
    input  logic msb_first,
    output rel_t next_rel
);

    logic invert_s;
    rel_t diff_s;

    // In two's complement the sign bit carries negative weight, so its sense flips.
    always_comb begin
        invert_s = is_signed & sign_bit;
        diff_s   = REL_EQ;
        next_rel = rel;
        if (a != b) begin
            if (a ^ invert_s) begin
                diff_s = REL_GT;
            end else begin
                diff_s = REL_LT;
            end
            if (msb_first) begin
                if (rel == REL_EQ) begin
                    next_rel = diff_s;
                end else begin
                    next_rel = rel;
                end
            end else begin
                next_rel = diff_s;
            end
        end else begin
            next_rel = rel;
        end
    end

endmodule

// File: rtl/seq_serial_comparator.sv
// Bit-serial signed/unsigned magnitude comparator with registered one-hot L/E/G result.
module seq_serial_comparator
    import seq_serial_comparator_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic res,
    input  logic start,
    input  logic is_signed,
    input  logic msb_first,
    input  logic bit_valid,
    input  logic a,
    input  logic b,
    output logic busy,
    output logic done,
    output logic L,
    output logic E,
    output logic G
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state_r;
    rel_t             rel_r;
    rel_t             next_rel_s;
    logic [CNT_W-1:0] cnt_r;
    logic             signed_r;
    logic             msb_first_r;
    logic             busy_r;
    logic             done_r;
    logic [2:0]       lge_r;
    logic             sign_bit_s;

    // For WIDTH=1 both orders resolve to index 0, which is then the sign bit.
    assign sign_bit_s = msb_first_r ? (cnt_r == {CNT_W{1'b0}}) : (cnt_r == LAST_IDX);

    seq_cmp_step u_step (
        .rel       (rel_r),
        .a         (a),
        .b         (b),
        .sign_bit  (sign_bit_s),
        .is_signed (signed_r),
        .msb_first (msb_first_r),
        .next_rel  (next_rel_s)
    );

    // Control FSM, pair counter, latched mode and registered outputs.
    always_ff @(posedge clk) begin
        if (res) begin
            state_r     <= S_IDLE;
            rel_r       <= REL_EQ;
            cnt_r       <= {CNT_W{1'b0}};
            signed_r    <= 1'b0;
            msb_first_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            lge_r       <= 3'b000;
        end else if (start) begin
            state_r     <= S_RUN;
            rel_r       <= REL_EQ;
            cnt_r       <= {CNT_W{1'b0}};
            signed_r    <= is_signed;
            msb_first_r <= msb_first;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            lge_r       <= 3'b000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                S_RUN: begin
                    if (bit_valid) begin
                        rel_r <= next_rel_s;
                        if (cnt_r == LAST_IDX) begin
                            state_r <= S_DONE;
                            cnt_r   <= {CNT_W{1'b0}};
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            lge_r   <= rel_to_lge(next_rel_s);
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    lge_r   <= 3'b000;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign L    = lge_r[2];
    assign E    = lge_r[1];
    assign G    = lge_r[0];

endmodule
